// File: rtl/proc_pkg.sv
// Shared processor definitions: default widths, loader FSM states and the boot image word.
package proc_pkg;

  localparam int unsigned INSTR_WIDTH_DEF = 10;
  localparam int unsigned ADDR_WIDTH_DEF  = 8;

  localparam logic [9:0] BOOT_WORD0 = 10'b1001000001;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_WRITE   = 2'd2,
    LD_DONE    = 2'd3
  } ld_state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/instr_ram.sv
// Synchronous RAM: one registered read port, one write port, preloaded boot image.
module instr_ram #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_WORD0 = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Power-up program image; the array itself is never touched by reset.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[ADDR_W'(i)] = '0;
    end
    mem[0] = INIT_WORD0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register resets to zero and holds when no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a one-cycle fetch port and a byte-stream program loader.
module instr_mem_loader
  import proc_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic [BYTE_WIDTH-1:0] load_byte,
  input  logic                  load_byte_valid,
  output logic                  load_ready,
  output logic                  loading,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned BPW    = ceil_div(INSTR_WIDTH, BYTE_WIDTH);
  localparam int unsigned BIDX_W = $clog2(BPW + 1);
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BPW - 1);

  ld_state_t               state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0]   word_ptr_q, word_ptr_d;
  logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [INSTR_WIDTH-1:0]  asm_q, asm_d;
  logic                    load_err_q, load_err_d;
  logic                    instr_valid_q, instr_valid_d;

  logic                    rd_en;
  logic                    wr_en;
  logic                    byte_xfer;
  logic [INSTR_WIDTH-1:0]  lane_hit;
  logic [INSTR_WIDTH-1:0]  lane_bits;

  // Static bit-to-byte lane map; bits at or above INSTR_WIDTH of the last byte are simply never mapped.
  for (genvar b = 0; b < INSTR_WIDTH; b++) begin : g_lane
    localparam logic [BIDX_W-1:0] LANE = BIDX_W'(b / BYTE_WIDTH);
    assign lane_hit[b]  = (byte_idx_q == LANE);
    assign lane_bits[b] = load_byte[b % BYTE_WIDTH];
  end

  assign byte_xfer = (state_q == LD_COLLECT) && load_byte_valid;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_ptr_d = word_ptr_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    load_err_d = load_err_q;
    wr_en      = 1'b0;

    unique case (state_q)
      LD_IDLE: begin
        if (load_start) begin
          if ((load_count != '0) && (load_count <= DEPTH_C)) begin
            count_d    = load_count;
            word_ptr_d = '0;
            byte_idx_d = '0;
            load_err_d = 1'b0;
            state_d    = LD_COLLECT;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      LD_COLLECT: begin
        if (byte_xfer) begin
          asm_d = (asm_q & ~lane_hit) | (lane_bits & lane_hit);
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            state_d    = LD_WRITE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      LD_WRITE: begin
        wr_en      = !reset;
        word_ptr_d = word_ptr_q + 1'b1;
        if ({1'b0, word_ptr_q} == (count_q - ONE_C)) begin
          state_d = LD_DONE;
        end else begin
          state_d = LD_COLLECT;
        end
      end
      LD_DONE: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  assign rd_en         = fetch_en && (state_q == LD_IDLE);
  assign instr_valid_d = rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LD_IDLE;
      count_q       <= '0;
      word_ptr_q    <= '0;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      load_err_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      word_ptr_q    <= word_ptr_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      load_err_q    <= load_err_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  instr_ram #(
    .WIDTH      (INSTR_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_WIDTH),
    .INIT_WORD0 (INSTR_WIDTH'(BOOT_WORD0))
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_addr (fetch_addr),
    .rd_data (instruction),
    .wr_en   (wr_en),
    .wr_addr (word_ptr_q),
    .wr_data (asm_q)
  );

  assign instr_valid = instr_valid_q;
  assign load_ready  = (state_q == LD_COLLECT);
  assign loading     = (state_q != LD_IDLE);
  assign load_done   = (state_q == LD_DONE);
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (default 10-bit words, 256-word memory).
module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_en;
  logic [7:0] fetch_addr;
  logic [9:0] instruction;
  logic       instr_valid;
  logic       load_start;
  logic [8:0] load_count;
  logic [7:0] load_byte;
  logic       load_byte_valid;
  logic       load_ready;
  logic       loading;
  logic       load_done;
  logic       load_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_nofetch = 1'b0;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         gap;
    logic [9:0] exp;
  } asm_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [9:0] exp;
  } fetch_vec_t;

  asm_vec_t   avec[5];
  fetch_vec_t fvec[4];

  instr_mem_loader #(
    .INSTR_WIDTH (10),
    .ADDR_WIDTH  (8),
    .BYTE_WIDTH  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .fetch_addr      (fetch_addr),
    .instruction     (instruction),
    .instr_valid     (instr_valid),
    .load_start      (load_start),
    .load_count      (load_count),
    .load_byte       (load_byte),
    .load_byte_valid (load_byte_valid),
    .load_ready      (load_ready),
    .loading         (loading),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fetch(input logic [7:0] a, input logic [9:0] exp);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick();
    check("fetch_valid", {31'b0, instr_valid}, 32'd1);
    check($sformatf("fetch_data[%0d]", a), {22'b0, instruction}, {22'b0, exp});
    fetch_en = 1'b0;
  endtask

  task automatic start_load(input logic [8:0] cnt);
    load_start = 1'b1;
    load_count = cnt;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    load_byte       = b;
    load_byte_valid = 1'b1;
    while (!load_ready && n < 16) begin
      tick();
      n++;
      if (chk_nofetch) check("fetch_dropped", {31'b0, instr_valid}, 32'd0);
    end
    if (!load_ready) check("load_ready_timeout", {31'b0, load_ready}, 32'd1);
    tick();
    if (chk_nofetch) check("fetch_dropped", {31'b0, instr_valid}, 32'd0);
    load_byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!load_done && n < 64) begin
      tick();
      n++;
      if (chk_nofetch) check("fetch_dropped", {31'b0, instr_valid}, 32'd0);
    end
    check("load_done_seen", {31'b0, load_done}, 32'd1);
  endtask

  function automatic logic [9:0] big_word(input int unsigned i);
    return 10'((i * 37) + 5);
  endfunction

  initial begin
    int d0;
    logic [9:0] w;

    avec[0] = '{8'h00, 8'h00, 1'b0, 10'h000};
    avec[1] = '{8'hFF, 8'hFF, 1'b1, 10'h3FF};
    avec[2] = '{8'h5A, 8'hFE, 1'b0, 10'h25A};
    avec[3] = '{8'hA5, 8'h01, 1'b1, 10'h1A5};
    avec[4] = '{8'h12, 8'h7C, 1'b1, 10'h012};

    fvec[0] = '{8'd0,   big_word(0)};
    fvec[1] = '{8'd1,   big_word(1)};
    fvec[2] = '{8'd128, big_word(128)};
    fvec[3] = '{8'd255, big_word(255)};

    reset = 1'b1; fetch_en = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_count = '0; load_byte = '0; load_byte_valid = 1'b0;
    tick(); tick(); tick();
    check("rst_instruction", {22'b0, instruction}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_load_ready",  {31'b0, load_ready},  32'd0);
    check("rst_loading",     {31'b0, loading},     32'd0);
    check("rst_load_done",   {31'b0, load_done},   32'd0);
    check("rst_load_err",    {31'b0, load_err},    32'd0);
    reset = 1'b0;
    tick();

    // Boot image and fetch hold behaviour
    fetch(8'd5, 10'h000);
    fetch(8'd0, 10'h241);
    tick();
    check("idle_valid_low", {31'b0, instr_valid}, 32'd0);
    check("idle_hold", {22'b0, instruction}, 32'h241);

    // Stray bytes while idle are ignored
    load_byte = 8'hEE; load_byte_valid = 1'b1;
    tick(); tick();
    check("stray_ready", {31'b0, load_ready}, 32'd0);
    check("stray_loading", {31'b0, loading}, 32'd0);
    load_byte_valid = 1'b0;

    // Two-word load
    d0 = done_cnt;
    start_load(9'd2);
    send_byte(8'h34);
    send_byte(8'h03);
    check("ready_in_write", {31'b0, load_ready}, 32'd0);
    send_byte(8'hFF);
    send_byte(8'h01);
    wait_done();
    check("loading_in_done", {31'b0, loading}, 32'd1);
    tick();
    check("loading_fell", {31'b0, loading}, 32'd0);
    check("done_one_cycle", {31'b0, load_done}, 32'd0);
    check("done_count_2w", done_cnt - d0, 32'd1);
    fetch(8'd0, 10'h334);
    fetch(8'd1, 10'h1FF);

    // Table: single-word loads with optional valid gaps
    for (int i = 0; i < 5; i++) begin
      start_load(9'd1);
      send_byte(avec[i].b0);
      if (avec[i].gap) begin
        load_byte = 8'hC3; load_byte_valid = 1'b0;
        tick();
        check("gap_ready", {31'b0, load_ready}, 32'd1);
      end
      send_byte(avec[i].b1);
      check("vec_ready_write", {31'b0, load_ready}, 32'd0);
      wait_done();
      tick();
      fetch(8'd0, avec[i].exp);
      fetch(8'd1, 10'h1FF);
    end

    // Out-of-range counts
    start_load(9'd0);
    check("err_cnt0", {31'b0, load_err}, 32'd1);
    check("err_cnt0_idle", {31'b0, loading}, 32'd0);
    tick();
    check("err_sticky", {31'b0, load_err}, 32'd1);
    start_load(9'd300);
    check("err_cnt300", {31'b0, load_err}, 32'd1);
    check("err_cnt300_idle", {31'b0, loading}, 32'd0);

    // Full-depth load
    d0 = done_cnt;
    start_load(9'd256);
    check("err_cleared", {31'b0, load_err}, 32'd0);
    check("full_loading", {31'b0, loading}, 32'd1);
    for (int unsigned i = 0; i < 256; i++) begin
      w = big_word(i);
      send_byte(w[7:0]);
      send_byte({6'b101101, w[9:8]});
    end
    wait_done();
    tick();
    check("full_done_count", done_cnt - d0, 32'd1);
    check("full_ptr_wrap", {24'b0, dut.word_ptr_q}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      fetch(fvec[i].addr, fvec[i].exp);
    end

    // Fetch during load dropped; mid-load starts ignored
    d0 = done_cnt;
    start_load(9'd2);
    fetch_en = 1'b1; fetch_addr = 8'd0;
    chk_nofetch = 1'b1;
    send_byte(8'h11);
    load_start = 1'b1; load_count = 9'd0;
    send_byte(8'h02);
    load_count = 9'd1;
    send_byte(8'h22);
    load_start = 1'b0;
    check("midload_err", {31'b0, load_err}, 32'd0);
    send_byte(8'h01);
    wait_done();
    chk_nofetch = 1'b0;
    fetch_en = 1'b0;
    tick();
    check("midload_done_count", done_cnt - d0, 32'd1);
    fetch(8'd0, 10'h211);
    fetch(8'd1, 10'h122);

    // Reset after three bytes of a two-word load
    d0 = done_cnt;
    start_load(9'd2);
    send_byte(8'h44);
    send_byte(8'h02);
    send_byte(8'h99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_loading", {31'b0, loading}, 32'd0);
    check("rst_mid_ready", {31'b0, load_ready}, 32'd0);
    check("rst_mid_done", {31'b0, load_done}, 32'd0);
    check("rst_mid_instr", {22'b0, instruction}, 32'd0);
    tick(); tick();
    check("rst_mid_no_done", done_cnt - d0, 32'd0);
    fetch(8'd0, 10'h244);
    fetch(8'd1, 10'h122);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
